cdc_fifo_word_assembler: RTL and testbench

- Reader-side consumer for the CDC FIFO output port; runs entirely in the FIFO's read clock domain.
- Drains narrow beats using the FIFO REQ/ACK protocol (REQ = valid from producer, ACK = accept from consumer; transfer when both high).
- Packs BEATS_PER_WORD beats into one wide word and presents it downstream on the same REQ/ACK protocol, with a per-beat valid mask.
- Partial words are emitted on explicit flush.

---
 rtl/cdc_fifo_word_assembler_pkg.sv | 15 +
 rtl/cdc_fifo_word_assembler_if.sv | 28 ++
 rtl/cdc_fifo_word_assembler_idle_timer.sv | 29 ++
 rtl/cdc_fifo_word_assembler.sv | 114 +++++++++++
 tb/tb_cdc_fifo_word_assembler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_fifo_word_assembler_pkg.sv
// cdc_fifo_pkg: shared types and helpers for the CDC FIFO word assembler.
//   asmState_t    - assembler state (FILL collecting beats, HOLD presenting a word)
//   beatIdxWidth  - clog2 with a minimum of 1, used for slot/counter indices
package cdc_fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asmState_t;

  function automatic int beatIdxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_fifo_word_assembler_if.sv
// cdc_fifo_word_assembler_if: REQ/ACK bundle around the word assembler.
//   Input side : InputREQ/InputACK/InputData  (narrow FIFO beats)
//   Flush      : FlushREQ (single-cycle partial-word emit request)
//   Output side: OutputREQ/OutputACK/OutputData/OutputBeatMask (wide word)
//   master - the assembler; slave - the surrounding FIFO / downstream logic.
interface cdc_fifo_word_assembler_if #(
  parameter int BEAT_BITWIDTH  = 8,
  parameter int BEATS_PER_WORD = 4
);
  logic                                    InputREQ;
  logic                                    InputACK;
  logic [BEAT_BITWIDTH-1:0]                InputData;
  logic                                    FlushREQ;
  logic                                    OutputREQ;
  logic                                    OutputACK;
  logic [BEAT_BITWIDTH*BEATS_PER_WORD-1:0] OutputData;
  logic [BEATS_PER_WORD-1:0]               OutputBeatMask;

  modport master (
    input  InputREQ, InputData, FlushREQ, OutputACK,
    output InputACK, OutputREQ, OutputData, OutputBeatMask
  );

  modport slave (
    output InputREQ, InputData, FlushREQ, OutputACK,
    input  InputACK, OutputREQ, OutputData, OutputBeatMask
  );
endinterface

// File: rtl/cdc_fifo_word_assembler_idle_timer.sv
// cdc_fifo_idle_timer: idle counter for the assembler auto-flush.
//   clk, sync_rst - read-side clock, synchronous active-high reset
//   run    - count this cycle (partial word waiting in FILL)
//   clear  - restart from zero (beat accepted or not in FILL)
//   expire - high in the TIMEOUT_CYCLES-th consecutive idle cycle
module cdc_fifo_idle_timer
  import cdc_fifo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic clk,
  input  logic sync_rst,
  input  logic run,
  input  logic clear,
  output logic expire
);
  localparam int CW = beatIdxWidth(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idleCnt;

  // Counts completed idle cycles; the cycle that sees LIMIT is the last idle one.
  always_ff @(posedge clk) begin
    if (sync_rst || clear)               idleCnt <= '0;
    else if (run && (idleCnt != LIMIT))  idleCnt <= idleCnt + 1'b1;
  end

  assign expire = run && !clear && (idleCnt == LIMIT);
endmodule

// File: rtl/cdc_fifo_word_assembler.sv
// cdc_fifo_word_assembler: packs BEATS_PER_WORD narrow FIFO beats into one
// wide word (beat 0 in the LSBs) with a per-beat valid mask. Read-clock domain.
//   clk, sync_rst - FIFO read clock, synchronous active-high reset
//   bus (master)  - InputREQ/ACK/Data beats in, FlushREQ, OutputREQ/ACK/Data/BeatMask out
// Optional: define CDC_FIFO_ASSEMBLER_TIMEOUT_EN to auto-flush a partial word
// after TIMEOUT_CYCLES idle cycles.
module cdc_fifo_word_assembler
  import cdc_fifo_pkg::*;
#(
  parameter int BEAT_BITWIDTH  = 8,
  parameter int BEATS_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 16
)(
  input logic                  clk,
  input logic                  sync_rst,
  cdc_fifo_word_assembler_if.master bus
);
  localparam int BCW = beatIdxWidth(BEATS_PER_WORD);
  localparam logic [BCW-1:0] LAST = BCW'(BEATS_PER_WORD - 1);

  asmState_t                                     state, stateNext;
  logic [BCW-1:0]                                beatCount, beatCountNext;
  logic [BEATS_PER_WORD-1:0][BEAT_BITWIDTH-1:0]  dataReg, dataNext;
  logic [BEATS_PER_WORD-1:0]                     maskReg, maskNext;
  logic [BEATS_PER_WORD-1:0]                     slotSel;
  logic                                          inputAck, accept, flushGo, timeoutFire;

  // HOLD forwards the downstream accept so a new beat can enter slot 0 in the
  // same cycle the previous word leaves.
  assign inputAck     = (state == FILL) ? 1'b1 : bus.OutputACK;
  assign accept       = bus.InputREQ && inputAck;
  assign bus.InputACK = inputAck;

  for (genvar i = 0; i < BEATS_PER_WORD; i++) begin : g_slot
    assign slotSel[i] = (beatCount == BCW'(i));
  end

`ifdef CDC_FIFO_ASSEMBLER_TIMEOUT_EN
  logic timerRun, timerClear;
  assign timerRun   = (state == FILL) && (beatCount != '0);
  assign timerClear = accept || (state != FILL);

  cdc_fifo_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idleTimer (
    .clk      (clk),
    .sync_rst (sync_rst),
    .run      (timerRun),
    .clear    (timerClear),
    .expire   (timeoutFire)
  );
`else
  assign timeoutFire = 1'b0;
`endif

  // An empty word is never emitted: a flush needs a stored or same-cycle beat.
  assign flushGo = (bus.FlushREQ || timeoutFire) && ((beatCount != '0) || accept);

  always_comb begin
    stateNext     = state;
    beatCountNext = beatCount;
    dataNext      = dataReg;
    maskNext      = maskReg;
    case (state)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < BEATS_PER_WORD; i++) begin
            if (slotSel[i]) begin
              dataNext[i] = bus.InputData;
              maskNext[i] = 1'b1;
            end
          end
          beatCountNext = beatCount + 1'b1;
        end
        // Count parks at 0 while holding so it never exceeds the last slot.
        if ((accept && (beatCount == LAST)) || flushGo) begin
          stateNext     = HOLD;
          beatCountNext = '0;
        end
      end
      HOLD: begin
        if (bus.OutputACK) begin
          dataNext      = '0;
          maskNext      = '0;
          beatCountNext = '0;
          stateNext     = FILL;
          if (bus.InputREQ) begin
            dataNext[0] = bus.InputData;
            maskNext[0] = 1'b1;
            if (BEATS_PER_WORD == 1) stateNext     = HOLD;
            else                     beatCountNext = BCW'(1);
          end
        end
      end
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state     <= FILL;
      beatCount <= '0;
      dataReg   <= '0;
      maskReg   <= '0;
    end else begin
      state     <= stateNext;
      beatCount <= beatCountNext;
      dataReg   <= dataNext;
      maskReg   <= maskNext;
    end
  end

  assign bus.OutputREQ      = (state == HOLD);
  assign bus.OutputData     = dataReg;
  assign bus.OutputBeatMask = maskReg;
endmodule

// File: tb/tb_cdc_fifo_word_assembler.sv
// Bench for cdc_fifo_word_assembler: a 4-beat instance and a 1-beat instance.
// Stimulus pushes expected words into queues; a negedge monitor pops and
// compares on every OutputREQ&&OutputACK handshake.
module tb_cdc_fifo_word_assembler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst1;

  cdc_fifo_word_assembler_if #(.BEAT_BITWIDTH(8), .BEATS_PER_WORD(4)) bus4();
  cdc_fifo_word_assembler_if #(.BEAT_BITWIDTH(8), .BEATS_PER_WORD(1)) bus1();

  cdc_fifo_word_assembler #(.BEAT_BITWIDTH(8), .BEATS_PER_WORD(4), .TIMEOUT_CYCLES(16)) dut4 (
    .clk(clk), .sync_rst(rst4), .bus(bus4));
  cdc_fifo_word_assembler #(.BEAT_BITWIDTH(8), .BEATS_PER_WORD(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .sync_rst(rst1), .bus(bus1));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
  } exp4_t;

  exp4_t      q4[$];
  logic [7:0] q1[$];
  int checks   = 0;
  int failures = 0;
  int words1   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic [7:0] d, input logic fl);
    bus4.InputREQ  = 1'b1;
    bus4.InputData = d;
    bus4.FlushREQ  = fl;
    tick();
  endtask

  task automatic idle4();
    bus4.InputREQ = 1'b0;
    bus4.FlushREQ = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp4_t e;
    logic [7:0] e1;
    if (!rst4 && bus4.OutputREQ && bus4.OutputACK) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL word4_unexpected actual=0x%0h required=none", bus4.OutputData);
      end else begin
        e = q4.pop_front();
        check("word4_data", 64'(bus4.OutputData), 64'(e.data));
        check("word4_mask", 64'(bus4.OutputBeatMask), 64'(e.mask));
      end
    end
    if (!rst1 && bus1.OutputREQ && bus1.OutputACK) begin
      words1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL word1_unexpected actual=0x%0h required=none", bus1.OutputData);
      end else begin
        e1 = q1.pop_front();
        check("word1_data", 64'(bus1.OutputData), 64'(e1));
        check("word1_mask", 64'(bus1.OutputBeatMask), 64'(1'b1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int reqSeen;
    logic [7:0] d;
    seen = 0;
    reqSeen = 0;
    bus4.InputREQ = 1'b0; bus4.InputData = '0; bus4.FlushREQ = 1'b0; bus4.OutputACK = 1'b0;
    bus1.InputREQ = 1'b0; bus1.InputData = '0; bus1.FlushREQ = 1'b0; bus1.OutputACK = 1'b0;
    rst4 = 1'b1; rst1 = 1'b1;
    tick(); tick();
    rst4 = 1'b0; rst1 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req",  64'(bus4.OutputREQ), 64'(0));
    check("rst_data", 64'(bus4.OutputData), 64'(0));
    check("rst_mask", 64'(bus4.OutputBeatMask), 64'(0));
    check("rst_ack",  64'(bus4.InputACK), 64'(1));

    // Full word, latency of OutputREQ
    bus4.OutputACK = 1'b1;
    q4.push_back('{32'h44332211, 4'b1111});
    beat4(8'h11, 1'b0); beat4(8'h22, 1'b0); beat4(8'h33, 1'b0);
    bus4.InputData = 8'h44;
    @(negedge clk);
    check("req_before_last", 64'(bus4.OutputREQ), 64'(0));
    tick();
    idle4();
    @(negedge clk);
    check("req_latency", 64'(bus4.OutputREQ), 64'(1));
    tick();

    // Backpressure, then handoff with 0x55 landing in slot 0
    bus4.OutputACK = 1'b0;
    q4.push_back('{32'h04030201, 4'b1111});
    beat4(8'h01, 1'b0); beat4(8'h02, 1'b0); beat4(8'h03, 1'b0); beat4(8'h04, 1'b0);
    bus4.InputData = 8'h55;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_ack",  64'(bus4.InputACK), 64'(0));
      check("bp_req",  64'(bus4.OutputREQ), 64'(1));
      check("bp_data", 64'(bus4.OutputData), 64'h04030201);
      tick();
    end
    bus4.OutputACK = 1'b1;
    q4.push_back('{32'h88776655, 4'b1111});
    tick();
    bus4.InputData = 8'h66;
    @(negedge clk);
    check("handoff_data", 64'(bus4.OutputData), 64'h55);
    check("handoff_mask", 64'(bus4.OutputBeatMask), 64'(1));
    check("handoff_req",  64'(bus4.OutputREQ), 64'(0));
    tick();
    beat4(8'h77, 1'b0); beat4(8'h88, 1'b0);
    idle4();
    tick(); tick();

    // Flush with a same-cycle beat; flush with nothing stored
    q4.push_back('{32'h0000BBAA, 4'b0011});
    beat4(8'hAA, 1'b0); beat4(8'hBB, 1'b1);
    idle4();
    tick(); tick();
    bus4.FlushREQ = 1'b1;
    tick();
    bus4.FlushREQ = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_empty_word", 64'(bus4.OutputREQ), 64'(0));
      tick();
    end

    // Reset while holding a word
    bus4.OutputACK = 1'b0;
    beat4(8'h10, 1'b0); beat4(8'h20, 1'b0); beat4(8'h30, 1'b0); beat4(8'h40, 1'b0);
    idle4();
    @(negedge clk);
    check("hold_before_rst", 64'(bus4.OutputREQ), 64'(1));
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    @(negedge clk);
    check("midrst_req",  64'(bus4.OutputREQ), 64'(0));
    check("midrst_mask", 64'(bus4.OutputBeatMask), 64'(0));
    check("midrst_data", 64'(bus4.OutputData), 64'(0));
    check("midrst_ack",  64'(bus4.InputACK), 64'(1));
    bus4.OutputACK = 1'b1;
    q4.push_back('{32'hC4C3C2C1, 4'b1111});
    tick();
    beat4(8'hC1, 1'b0); beat4(8'hC2, 1'b0); beat4(8'hC3, 1'b0); beat4(8'hC4, 1'b0);
    idle4();
    tick(); tick();

    // Idle timeout behaviour
    q4.push_back('{32'h0000007E, 4'b0001});
    beat4(8'h7E, 1'b0);
    idle4();
`ifdef CDC_FIFO_ASSEMBLER_TIMEOUT_EN
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(negedge clk);
      if (bus4.OutputREQ) seen = k;
      else tick();
    end
    check("timeout_latency", 64'(seen), 64'(17));
    tick(); tick();
`else
    repeat (100) begin
      @(negedge clk);
      if (bus4.OutputREQ) reqSeen++;
      tick();
    end
    check("no_timeout", 64'(reqSeen), 64'(0));
    bus4.FlushREQ = 1'b1;
    tick();
    bus4.FlushREQ = 1'b0;
    tick(); tick();
`endif

    // Single-beat words streaming at full rate
    bus1.OutputACK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'(i * 17 + 3);
      q1.push_back(d);
      bus1.InputREQ  = 1'b1;
      bus1.InputData = d;
      @(negedge clk);
      check("stream1_ack", 64'(bus1.InputACK), 64'(1));
      tick();
    end
    bus1.InputREQ = 1'b0;
    tick(); tick();
    check("stream1_words", 64'(words1), 64'(8));

    check("q4_drained", 64'(q4.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
